// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// Imported by rr_pick and mux_rr_scheduler.
package mux_sched_pkg;

  localparam int unsigned N_REQ_C  = 31;
  localparam int unsigned SEL_W_C  = 5;
  localparam int unsigned DATA_W_C = 8;
  localparam int unsigned LAST_IDX = 30;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: lowest requesting index at or
// above ptr, wrapping to index 0 after N-1.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int unsigned N     = N_REQ_C,
  parameter int unsigned SEL_W = SEL_W_C
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] win_o,
  output logic             any_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  always_comb begin
    dbl    = {req_i, req_i};
    masked = '0;
    win_o  = '0;
    found  = 1'b0;
    any_o  = |req_i;
    // Upper copy is never masked, so a hit there is a wrapped grant.
    for (int unsigned i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= 32'(ptr_i));
    end
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        win_o = (i >= N) ? SEL_W'(i - N) : SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a 31:1 byte mux: grants one requester,
// waits one settle cycle, captures the mux byte and offers it valid/ready.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_C,
  parameter int unsigned SEL_W  = SEL_W_C,
  parameter int unsigned DATA_W = DATA_W_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [N_REQ-1:0]  ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [SEL_W-1:0]    mux_sel_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [N_REQ-1:0]    ack_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [SEL_W-1:0]    win_d;
  logic                any_d;

  rr_pick #(
    .N     (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win_d),
    .any_o (any_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_sel_q   <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            mux_sel_q <= win_d;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          out_data_q  <= mux_data;
          out_valid_q <= 1'b1;
          ack_q       <= ONE_HOT0 << mux_sel_q;
          ptr_q       <= (mux_sel_q == LAST_SEL) ? '0 : mux_sel_q + SEL_W'(1);
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mux_sel   = mux_sel_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
